uart_tx_fifo: RTL
=================

# uart_tx_fifo

Byte buffer and launch sequencer sitting directly upstream of `UART_Tx`. Accepts bytes from the host side at up to one per clock, stores them in a DEPTH-entry FIFO, and feeds them one at a time to `UART_Tx` through its `start_sending`/`data_in`/`busy`/`done` handshake. This lets the host queue a burst without waiting out each serial frame.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 2.
- `ADDR_W`, 4: equals log2(`DEPTH`).
- `clk`  in  1: system clock, shared with `UART_Tx`.
- `rst`  in  1: synchronous, active-high reset.
- `wr_en`  in  1: push `wr_data` this cycle.
- `wr_data`  in  8: byte to queue.
- `full`  out  1: FIFO holds `DEPTH` bytes.
- `empty`  out  1: FIFO holds 0 bytes.
- `count`  out  ADDR_W+1: current occupancy, 0..`DEPTH`.
- `overflow`  out  1: sticky; a write was dropped.
- `tx_start`  out  1: drives `UART_Tx.start_sending`; one-cycle pulse.
- `tx_data`  out  8: drives `UART_Tx.data_in`.
- `tx_busy`  in  1: from `UART_Tx.busy`.
- `tx_done`  in  1: from `UART_Tx.done`; one-cycle pulse at the end of the stop bit.

## Operation
- Storage: 8-bit RAM with `DEPTH` entries. `wr_ptr` and `rd_ptr` are ADDR_W bits wide and wrap modulo `DEPTH`. `count` is a registered value.
- Push: when `wr_en` is high and `full` is low at the edge, write `mem[wr_ptr]`, increment `wr_ptr`, and increment `count`.
- Push while full: the write is dropped, pointers are unchanged, and `overflow` is set to 1. It stays set until `rst`.
- Pop: occurs only in state IDLE, as described below. It loads `tx_data` from `mem[rd_ptr]`, increments `rd_ptr`, and decrements `count`.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- `full` is evaluated on pre-edge state. A push while full is dropped even if a pop happens in the same cycle.
- `full` = (`count` == `DEPTH`). `empty` = (`count` == 0). Both are derived combinationally from the registered `count`.
- FSM states:
  - IDLE: if `empty` is low and `tx_busy` is low, pop and go to LAUNCH. Otherwise stay.
  - LAUNCH: `tx_start` = 1 for exactly this cycle, then go to WAIT.
  - WAIT: on `tx_done` = 1, go to GAP. Otherwise stay.
  - GAP: one idle cycle, then go to IDLE. This guarantees `tx_busy` has been observed low by `UART_Tx` before the next start.
- `tx_done` pulses seen outside WAIT are ignored.
- `tx_data` is registered. It changes only on a pop and holds from the pop until the next pop.
- Reset values:
  - FIFO: `count` = 0, both pointers = 0, `empty` = 1, `full` = 0.
  - Outputs: `overflow` = 0, `tx_start` = 0, `tx_data` = 8'h00.
  - FSM: IDLE.
  - RAM contents are not reset.
- Reset mid-frame: all queued bytes are discarded and the FSM returns to IDLE. `UART_Tx` has no reset and finishes its frame on the line. The IDLE gating on `tx_busy` blocks any new launch until that frame ends.

## Timing
- Write-to-launch latency from an empty FIFO, when `UART_Tx` is idle:
  - `wr_en` is sampled at edge N, so `count` = 1 after N.
  - Pop at edge N+1: `tx_data` is valid and the FSM is in LAUNCH, so `tx_start` is high during cycle N+1..N+2.
  - At edge N+2, `UART_Tx` samples `start_sending` = 1 and the FSM moves to WAIT.
- Byte-to-byte spacing: `tx_done` is sampled at edge D. The FSM is in GAP during D..D+1 and in IDLE at D+1. If the FIFO is non-empty and `tx_busy` is low, the pop occurs at D+1 and the next `tx_start` is high during D+1..D+2. The spacing from `tx_done` to the next `tx_start` is therefore 1 cycle of GAP.
- Serial throughput is limited by `UART_Tx`: one 10-bit frame per 10·`CLKs_per_bit` clocks plus a 3-cycle launch overhead.
- `overflow` rises on the edge that drops the write.

## Test plan
- Single byte: reset, push 8'hA6 into an idle FIFO.
  - `tx_start` pulses exactly 2 edges after the `wr_en` edge, with `tx_data` = 8'hA6.
  - The `UART_Rx` loopback yields 8'hA6.
  - After the pop, `count` returns to 0.
- Burst in order: push 8'hA6, 8'h00, 8'hFF, 8'h55 on consecutive cycles, with `CLKs_per_bit` = 100.
  - `count` peaks at 3 (the first byte pops at once).
  - `UART_Rx` receives the 4 bytes in order.
  - Consecutive `tx_start` pulses are about 1003 clocks apart.
  - `empty` = 1 after the last pop.
- Full/overflow with `DEPTH` = 16: hold `UART_Tx` busy by forcing `tx_busy` = 1, then push 17 bytes 8'h00..8'h10.
  - `full` = 1 after the 16th push.
  - 8'h10 is dropped and `overflow` = 1.
  - Released, the transmitted bytes are 8'h00..8'h0F only.
- Wrap-around: push and drain 40 bytes with mixed timing.
  - Pointers wrap twice.
  - The data sequence is preserved.
  - `count` never exceeds 16 or underflows.
- Simultaneous push/pop: with `count` = 3, assert `wr_en` on the cycle of a pop.
  - `count` stays 3 and both pointers advance.
- Reset mid-frame: assert `rst` for 1 cycle during byte 2 of a 4-byte burst.
  - `count` = 0 and `tx_start` = 0.
  - No new `tx_start` appears until `tx_busy` falls.
  - Byte 2 completes on the line; bytes 3 and 4 are never sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of UART_Tx: queues host bytes and launches them one frame at a time
// through the start_sending/busy/done handshake.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    input  logic              tx_done
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [0:DEPTH-1];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    state_t            state;
    logic              push;
    logic              pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign pop   = (state == IDLE) && !empty && !tx_busy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // GAP gives UART_Tx one cycle to drop busy before IDLE may launch the next byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: state <= WAIT;
                WAIT: begin
                    if (tx_done) begin
                        state <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
